// File: rtl/mac_pkg.sv
// Shared constants and state encoding for the sequential two-term MAC.
package mac_pkg;

    localparam int unsigned DefaultWidth = 8;
    localparam int unsigned StepCntWidth = $clog2(DefaultWidth) + 1;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StMulAb = 2'd1,
        StMulCd = 2'd2,
        StDone  = 2'd3
    } state_e;

endpackage

// File: rtl/shift_add_datapath.sv
// Shared shift-add multiplier datapath: one partial-product step per enabled cycle into a
// single accumulator that spans both products.
module shift_add_datapath
    import mac_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clr,
    input  logic               load_ab,
    input  logic               load_cd,
    input  logic               step,
    input  logic [WIDTH-1:0]   mcand_in,
    input  logic [WIDTH-1:0]   mplier_in,
    output logic [2*WIDTH:0]   acc,
    output logic               last_step
);

    logic [2*WIDTH-1:0]      mcand_q, mcand_d;
    logic [WIDTH-1:0]        mplier_q, mplier_d;
    logic [2*WIDTH:0]        acc_q, acc_d;
    logic [StepCntWidth-1:0] cnt_q, cnt_d;

    assign last_step = (cnt_q == StepCntWidth'(WIDTH - 1));
    // Exposes the sum including the current step so the caller can capture it on the last step.
    assign acc = acc_d;

    always_comb begin
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        if (clr) begin
            acc_d = '0;
            cnt_d = '0;
        end else if (step) begin
            acc_d    = acc_q + (mplier_q[0] ? {1'b0, mcand_q} : '0);
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = last_step ? '0 : cnt_q + 1'b1;
        end
        // A load overrides the shift so the next product starts on the following cycle.
        if (load_ab || load_cd) begin
            mcand_d  = {{WIDTH{1'b0}}, mcand_in};
            mplier_d = mplier_in;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/seq_dot2_mac.sv
// Sequential a*b + c*d over a shared shift-add datapath; fixed 2*WIDTH-cycle latency,
// registered result/carry/done.
module seq_dot2_mac
    import mac_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [WIDTH-1:0]   c,
    input  logic [WIDTH-1:0]   d,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] result,
    output logic               carry
);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   c_q, d_q;
    logic [2*WIDTH-1:0] result_q, result_d;
    logic               carry_q, carry_d;
    logic               done_q, done_d;

    logic               clr, load_ab, load_cd, step, last_step;
    logic [2*WIDTH:0]   acc;
    logic [WIDTH-1:0]   mcand_in, mplier_in;

    // a/b go straight into the datapath on the start edge; c/d wait in holding regs.
    assign mcand_in  = load_ab ? a : c_q;
    assign mplier_in = load_ab ? b : d_q;

    shift_add_datapath #(
        .WIDTH (WIDTH)
    ) u_datapath (
        .clk       (clk),
        .reset     (reset),
        .clr       (clr),
        .load_ab   (load_ab),
        .load_cd   (load_cd),
        .step      (step),
        .mcand_in  (mcand_in),
        .mplier_in (mplier_in),
        .acc       (acc),
        .last_step (last_step)
    );

    always_comb begin
        state_d  = state_q;
        clr      = 1'b0;
        load_ab  = 1'b0;
        load_cd  = 1'b0;
        step     = 1'b0;
        result_d = result_q;
        carry_d  = carry_q;
        done_d   = 1'b0;
        case (state_q)
            StIdle: begin
                if (start) begin
                    clr     = 1'b1;
                    load_ab = 1'b1;
                    state_d = StMulAb;
                end
            end
            StMulAb: begin
                step = 1'b1;
                if (last_step) begin
                    load_cd = 1'b1;
                    state_d = StMulCd;
                end
            end
            StMulCd: begin
                step = 1'b1;
                if (last_step) begin
                    {carry_d, result_d} = acc;
                    done_d              = 1'b1;
                    state_d             = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= StIdle;
            c_q      <= '0;
            d_q      <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            done_q   <= done_d;
            if (load_ab) begin
                c_q <= c;
                d_q <= d;
            end
        end
    end

    assign busy   = (state_q != StIdle);
    assign done   = done_q;
    assign result = result_q;
    assign carry  = carry_q;

endmodule

// File: tb/tb_seq_dot2_mac.sv
// Directed and random checks of seq_dot2_mac against an arithmetic reference a*b + c*d.
module tb_seq_dot2_mac;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  a = '0, b = '0, c = '0, d = '0;
    logic        busy, done, carry;
    logic [15:0] result;

    int errors = 0;
    int checks = 0;
    logic [15:0] prev_result = '0;

    seq_dot2_mac dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .a      (a),
        .b      (b),
        .c      (c),
        .d      (d),
        .busy   (busy),
        .done   (done),
        .result (result),
        .carry  (carry)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One full transaction; optional re-pulse of start mid-run with scrambled operands.
    task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_, input logic [7:0] tc,
                          input logic [7:0] td, input bit bump, input string tag);
        int n;
        logic [16:0] exp;
        exp = 17'(int'(ta) * int'(tb_) + int'(tc) * int'(td));
        @(negedge clk);
        a = ta; b = tb_; c = tc; d = td;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        chk({tag, "_hold"}, 32'(result), 32'(prev_result));
        a = 8'($urandom); b = 8'($urandom); c = 8'($urandom); d = 8'($urandom);
        n = 0;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
            if (bump) start = (n == 5);
        end
        start = 1'b0;
        chk({tag, "_lat"}, 32'(n), 32'd16);
        chk({tag, "_res"}, 32'(result), 32'(exp[15:0]));
        chk({tag, "_cy"}, 32'(carry), 32'(exp[16]));
        prev_result = exp[15:0];
        @(negedge clk);
        chk({tag, "_dfall"}, 32'(done), 32'd0);
        @(negedge clk);
        chk({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int last, pulses;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_res", 32'(result), 32'd0);
        chk("rst_cy", 32'(carry), 32'd0);
        reset = 1'b1;

        run_op(8'd3, 8'd5, 8'd7, 8'd9, 1'b0, "t1");
        chk("t1_const", 32'(result), 32'h004E);

        run_op(8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b0, "t2");
        chk("t2_const", 32'({carry, result}), 32'h1FC02);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("t2_held", 32'({carry, result, done}), 32'({1'b1, 16'hFC02, 1'b0}));
        end

        run_op(8'hFF, 8'hFF, 8'h00, 8'h00, 1'b0, "t3a");
        run_op(8'h00, 8'h00, 8'h80, 8'h02, 1'b0, "t3b");
        run_op(8'd2, 8'd3, 8'd4, 8'd5, 1'b1, "t4");
        repeat (20) begin
            @(negedge clk);
            chk("t4_nosecond", 32'({busy, done}), 32'd0);
        end

        // Reset mid-computation.
        @(negedge clk);
        a = 8'd9; b = 8'd9; c = 8'd9; d = 8'd9;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_done", 32'(done), 32'd0);
        chk("t5_res", 32'(result), 32'd0);
        chk("t5_cy", 32'(carry), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        prev_result = '0;
        run_op(8'd1, 8'd1, 8'd1, 8'd1, 1'b0, "t5");

        for (int i = 0; i < 8; i++)
            run_op(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 1'($urandom), "rnd");

        // Back-to-back with start held high.
        @(negedge clk);
        a = 8'h10; b = 8'h10; c = 8'h10; d = 8'h10;
        start = 1'b1;
        last = -1;
        pulses = 0;
        for (int cyc = 0; cyc < 60; cyc++) begin
            @(negedge clk);
            if (done) begin
                pulses++;
                chk("t6_res", 32'({carry, result}), 32'h00200);
                if (last >= 0) chk("t6_period", 32'(cyc - last), 32'd18);
                last = cyc;
            end
        end
        start = 1'b0;
        chk("t6_pulses", 32'(pulses), 32'd3);
        for (int i = 0; i < 40 && busy; i++) @(negedge clk);
        chk("t6_idle", 32'(busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
